// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt controller: register offsets, FSM states
// and the MIPS exception code used in the cause word.
package irq_pkg;

  localparam logic [1:0] REG_PEND = 2'd0;
  localparam logic [1:0] REG_EN   = 2'd1;
  localparam logic [1:0] REG_ISR  = 2'd2;
  localparam logic [1:0] REG_EOI  = 2'd3;

  localparam logic [4:0] EXC_INT = 5'd0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_SVC  = 2'd2
  } state_t;

  function automatic logic [7:0] onehot8(input logic [2:0] id);
    return 8'b1 << id;
  endfunction

endpackage

// File: rtl/irq_controller_if.sv
// Bus and CPU-side signals of the interrupt controller; the slave modport is
// the controller's view, the master modport is the CPU/bus view.
interface irq_controller_if;

  logic        sel;
  logic        wren;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        inta;
  logic        intr;
  logic [2:0]  irq_id;
  logic        in_svc;
  logic [31:0] irq_cause;

  modport master (
    output sel, wren, addr, wdata, inta,
    input  rdata, intr, irq_id, in_svc, irq_cause
  );

  modport slave (
    input  sel, wren, addr, wdata, inta,
    output rdata, intr, irq_id, in_svc, irq_cause
  );

endinterface

// File: rtl/prio_enc8.sv
// Combinational 8-input priority encoder; the lowest set index wins.
module prio_enc8 (
  input  logic [7:0] req,
  output logic       valid,
  output logic [2:0] id
);

  // Scan from the top down so the lowest set bit is the last assignment.
  always_comb begin
    valid = |req;
    id    = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (req[i]) id = 3'(i);
    end
  end

endmodule

// File: rtl/irq_controller.sv
// Edge-latching interrupt controller with enable mask, fixed priority and a
// req/ack/EOI handshake towards the MIPS core.
module irq_controller
  import irq_pkg::*;
#(
  parameter int         NUM_IRQ  = 8,
  parameter logic [7:0] EN_RESET = 8'h00
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_IRQ-1:0] irq,
  irq_controller_if.slave    bus
);

  localparam logic [8:0] ONE_SHIFTED = 9'd1 << NUM_IRQ;
  localparam logic [7:0] VALID_MASK  = 8'(ONE_SHIFTED - 9'd1);

  logic [7:0] irq_ext;
  logic [7:0] irq_d;
  logic [7:0] pending;
  logic [7:0] enable;
  logic [7:0] cand;
  logic [7:0] edges;
  logic [7:0] w1c_clear;
  logic [7:0] ack_clear;
  state_t     state;
  state_t     state_next;
  logic [2:0] sel_id;
  logic [2:0] sel_id_next;
  logic [2:0] irq_id_q;
  logic       win_valid;
  logic [2:0] win_id;
  logic       take_ack;
  logic       wr_pend;
  logic       wr_en;
  logic       wr_eoi;

  always_comb begin
    irq_ext              = 8'h00;
    irq_ext[NUM_IRQ-1:0] = irq;
  end

  assign edges     = irq_ext & ~irq_d;
  assign cand      = pending & enable;
  assign wr_pend   = bus.sel & bus.wren & (bus.addr[3:2] == REG_PEND);
  assign wr_en     = bus.sel & bus.wren & (bus.addr[3:2] == REG_EN);
  assign wr_eoi    = bus.sel & bus.wren & (bus.addr[3:2] == REG_EOI);
  assign w1c_clear = wr_pend ? bus.wdata[7:0] : 8'h00;
  assign ack_clear = take_ack ? onehot8(sel_id) : 8'h00;

  prio_enc8 u_prio (
    .req   (cand),
    .valid (win_valid),
    .id    (win_id)
  );

  // A higher-priority candidate can preempt the request until inta arrives.
  always_comb begin
    state_next  = state;
    sel_id_next = sel_id;
    take_ack    = 1'b0;
    case (state)
      S_IDLE: begin
        if (win_valid) begin
          sel_id_next = win_id;
          state_next  = S_REQ;
        end
      end
      S_REQ: begin
        if (bus.inta) begin
          take_ack   = 1'b1;
          state_next = S_SVC;
        end else if (!cand[sel_id]) begin
          state_next = S_IDLE;
        end else if (win_id < sel_id) begin
          sel_id_next = win_id;
        end
      end
      S_SVC: begin
        if (wr_eoi) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Set wins over both clear sources because edges are OR-ed in last.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= S_IDLE;
      sel_id   <= 3'd0;
      irq_id_q <= 3'd0;
      pending  <= 8'h00;
      enable   <= EN_RESET & VALID_MASK;
      irq_d    <= irq_ext;
    end else begin
      state   <= state_next;
      sel_id  <= sel_id_next;
      pending <= ((pending & ~w1c_clear & ~ack_clear) | edges) & VALID_MASK;
      irq_d   <= irq_ext;
      if (take_ack) irq_id_q <= sel_id;
      if (wr_en) enable <= bus.wdata[7:0] & VALID_MASK;
    end
  end

  assign bus.intr      = (state == S_REQ);
  assign bus.in_svc    = (state == S_SVC);
  assign bus.irq_id    = irq_id_q;
  assign bus.irq_cause = {16'h0000, cand, 1'b0, EXC_INT, 2'b00};

  always_comb begin
    bus.rdata = 32'h0000_0000;
    case (bus.addr[3:2])
      REG_PEND: bus.rdata = {24'h000000, pending};
      REG_EN:   bus.rdata = {24'h000000, enable};
      REG_ISR:  bus.rdata = {bus.in_svc, 28'h0000000, irq_id_q};
      default:  bus.rdata = 32'h0000_0000;
    endcase
  end

endmodule

// File: doc/irq_controller.md
Name: irq_controller

Overview:
- Interrupt controller for the single-cycle MIPS core's exception path.
- Latches rising edges from up to 8 external interrupt sources and applies a software enable mask.
- Picks the highest-priority pending source and drives the CPU's intr line with a req/ack handshake against inta.
- Holds the in-service source until software writes EOI; while holding, it supplies the source id and a MIPS-style cause word to the CAUSE path.
- Software programs it through word-addressed memory-mapped registers on the data-memory bus (addr, wren, write data from busB).

Parameters:
NUM_IRQ, 8, number of interrupt sources (1..8); source 0 has the highest priority.
EN_RESET, 8'h00, reset value of the enable mask (bit=1 means enabled).

Ports:
clk  input  1  core clock, rising edge.
reset  input  1  synchronous active-low reset; sampled on the rising edge of clk.
irq  input  NUM_IRQ  raw interrupt sources; rising-edge sensitive; already synchronous to clk.
inta  input  1  CPU interrupt acknowledge; one-cycle pulse.
sel  input  1  register-window select, decoded from addr by the bus.
wren  input  1  register write enable; qualified by sel.
addr  input  32  byte address; only addr[3:2] are used.
wdata  input  32  write data (busB).
rdata  output  32  read data; combinational from addr[3:2].
intr  output  1  interrupt request to the CPU; registered.
irq_id  output  3  in-service source id; valid when in_svc=1.
in_svc  output  1  a source is currently in service.
irq_cause  output  32  cause word: [15:8] = pending & enable (zero-extended), [6:2] = 0 (Int ExcCode), all other bits 0.

Behaviour:
- Registers (addr[3:2]):
  - 0 PEND: read returns pending. Write-1-to-clear.
  - 1 EN: read/write enable mask.
  - 2 ISR: read returns {in_svc at [31], 28'b0, irq_id at [2:0]}. Writes are ignored.
  - 3 EOI: a write of any value ends service. Reads return 0.
  - Bits at NUM_IRQ and above read as 0 and ignore writes.
- Edge detect:
  - irq_d is a registered copy of irq.
  - edge = irq & ~irq_d.
  - pending <= (pending & ~w1c_clear & ~ack_clear) | edge.
  - When a set and a clear hit the same bit in the same cycle, set wins.
- Arbitration: cand = pending & enable. The winner is the lowest-index set bit of cand.
- FSM states IDLE, REQ, SVC:
  - IDLE: if cand != 0, latch winner into sel_id and go to REQ. intr=0.
  - REQ: intr=1.
    - If inta=1: clear pending[sel_id], set irq_id=sel_id and in_svc=1, go to SVC.
    - Else if cand[sel_id]=0 (masked or W1C-cleared): go to IDLE, intr drops next cycle.
    - Else if a higher-priority source becomes a candidate: update sel_id and stay in REQ.
  - SVC: intr=0.
    - On an EOI write, in_svc=0 and go to IDLE.
    - Re-arbitration resumes the next cycle, so back-to-back interrupts are allowed.
    - No nesting.
- Ignored events: inta in IDLE or SVC; EOI in IDLE or REQ.
- Latency:
  - An irq rise first sampled at edge k sets pending at edge k.
  - The FSM enters REQ at edge k+1, so intr is high after k+1.
  - irq_id and in_svc are valid after the edge that samples inta.
- Reset, when reset=0 at a rising edge:
  - FSM=IDLE, pending=0, enable=EN_RESET, irq_d=irq.
  - intr=0, in_svc=0, irq_id=0.
  - Reset mid-REQ or mid-SVC aborts with no EOI required.
- Register writes and FSM updates in the same cycle: the EN write takes effect for arbitration starting the next cycle.

Decomposition:
- Shared package irq_pkg holds:
  - register offsets: REG_PEND=2'd0, REG_EN=2'd1, REG_ISR=2'd2, REG_EOI=2'd3
  - FSM state encodings: S_IDLE, S_REQ, S_SVC
  - the ExcCode constant EXC_INT=5'd0
- One natural sub-module: prio_enc8, a combinational lowest-index-first priority encoder with outputs valid and id.

Test Plan:
1. Reset with irq=8'h00, then write EN=8'h04 and pulse irq[2] -> PEND=8'h04; intr=1 two edges after the rise; inta pulse -> irq_id=2, in_svc=1, PEND=0, intr=0; EOI write -> in_svc=0.
2. With EN=8'hFF, raise irq[5] and irq[1] in the same cycle -> first service irq_id=1; after EOI, intr reasserts and second service irq_id=5.
3. With EN=8'h08, pulse irq[3] and write EN=8'h00 while in REQ, before inta -> intr falls next cycle, FSM=IDLE, PEND still 8'h08, irq_cause[15:8]=8'h00.
4. In REQ on id 6, raise irq[0] with EN=8'hFF -> sel_id switches to 0; inta -> irq_id=0, PEND keeps bit 6 (8'h40).
5. Write PEND=8'h10 (W1C) in the same cycle as a new irq[4] edge -> bit 4 remains set (set wins); a W1C in a later cycle clears it to 8'h00.
6. Drive reset=0 for one edge during SVC -> intr=0, in_svc=0, PEND=0, EN=EN_RESET; a stray EOI or inta afterwards has no effect.
